pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshaking, a two-entry skid buffer and a synchronous flush. It replaces the fixed-width, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block, so each stage can stall, drain or be squashed without losing or duplicating an instruction. It is instantiated once per pipeline boundary. Payload fields are concatenated into `in_data`, and write-enable style controls into `in_ctrl`.

---
 rtl/pipe_stage_reg.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, two-entry skid buffer, synchronous flush.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_t;

  logic              r_main_valid, r_skid_valid, r_in_ready;
  logic [DATA_W-1:0] r_main_data, r_skid_data;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;

  logic              w_main_valid, w_skid_valid;
  logic [DATA_W-1:0] w_main_data, w_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl;
  logic              w_accept, w_emit;
  state_t            w_state;

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_main_valid & out_ready;

  // State is implied by the entry valid bits; 2'b10 cannot occur.
  always_comb begin
    w_state = state_t'({r_skid_valid, r_main_valid});
  end

  always_comb begin
    w_main_valid = r_main_valid;
    w_skid_valid = r_skid_valid;
    w_main_data  = r_main_data;
    w_skid_data  = r_skid_data;
    w_main_ctrl  = r_main_ctrl;
    w_skid_ctrl  = r_skid_ctrl;
    if (flush) begin
      w_main_valid = 1'b0;
      w_skid_valid = 1'b0;
      w_main_ctrl  = {CTRL_W{1'b0}};
      w_skid_ctrl  = {CTRL_W{1'b0}};
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_valid = 1'b1;
            w_main_data  = in_data;
            w_main_ctrl  = in_ctrl;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            w_main_data = in_data;
            w_main_ctrl = in_ctrl;
          end else if (w_accept) begin
            w_skid_valid = 1'b1;
            w_skid_data  = in_data;
            w_skid_ctrl  = in_ctrl;
          end else if (w_emit) begin
            w_main_valid = 1'b0;
            w_main_ctrl  = {CTRL_W{1'b0}};
          end
        end
        ST_TWO: begin
          if (w_emit) begin
            w_main_data  = r_skid_data;
            w_main_ctrl  = r_skid_ctrl;
            w_skid_valid = 1'b0;
            w_skid_ctrl  = {CTRL_W{1'b0}};
          end
        end
        default: begin
          w_main_valid = 1'b0;
          w_skid_valid = 1'b0;
          w_main_ctrl  = {CTRL_W{1'b0}};
          w_skid_ctrl  = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // in_ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_main_data  <= {DATA_W{1'b0}};
      r_skid_data  <= {DATA_W{1'b0}};
      r_main_ctrl  <= {CTRL_W{1'b0}};
      r_skid_ctrl  <= {CTRL_W{1'b0}};
    end else begin
      r_main_valid <= w_main_valid;
      r_skid_valid <= w_skid_valid;
      r_in_ready   <= ~w_skid_valid;
      r_main_data  <= w_main_data;
      r_skid_data  <= w_skid_data;
      r_main_ctrl  <= w_main_ctrl;
      r_skid_ctrl  <= w_skid_ctrl;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;
  logic             w_stall_sat, w_bubble_sat;

  assign w_stall_sat  = (r_stall_cnt  == {CNT_W{1'b1}});
  assign w_bubble_sat = (r_bubble_cnt == {CNT_W{1'b1}});

  // Saturating counters; flush does not touch them.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_main_valid && !out_ready && !w_stall_sat) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!r_main_valid && !w_bubble_sat) begin
        r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random handshakes
// compared against a queue-based model of the stage contents.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  logic          CLK = 1'b0;
  logic          RSTn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt, bubble_cnt;
`endif

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  int    total = 0;
  int    bad = 0;
  beat_t q[$];
  bit    m_rdy = 1'b0;
  int    m_stall = 0;
  int    m_bubble = 0;
  bit    seen_dead = 1'b0;

  // Watch for the squashed beat ever leaving the stage.
  always @(posedge CLK) begin
    if (RSTn && out_valid && out_ready && out_data == 32'hDEAD_BEEF) seen_dead <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit iv, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input bit fl, input bit ordy);
    bit acc;
    bit em;
    beat_t b;
    @(negedge CLK);
    RSTn = rst; in_valid = iv; in_data = d; in_ctrl = c; flush = fl; out_ready = ordy;
    @(posedge CLK);
    if (!rst) begin
      q.delete();
      m_rdy = 1'b0;
      m_stall = 0;
      m_bubble = 0;
    end else begin
      acc = iv && m_rdy;
      em  = (q.size() > 0) && ordy;
      if (q.size() > 0 && !ordy && m_stall < SAT) m_stall++;
      if (q.size() == 0 && m_bubble < SAT) m_bubble++;
      if (fl) begin
        q.delete();
      end else begin
        if (em) void'(q.pop_front());
        if (acc) begin
          b.d = d;
          b.c = c;
          q.push_back(b);
        end
      end
      m_rdy = (q.size() < 2);
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("out_ctrl", 64'(out_ctrl), (q.size() > 0) ? 64'(q[0].c) : 64'd0);
    if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0].d));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
  endtask

  initial begin
    RSTn = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("bubble_after_3_idle", 64'(bubble_cnt), 64'd3);
`endif

    // Streaming 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'h10 + 32'(i), 3'b101, 1'b0, 1'b1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_data", 64'(out_data), 64'h10 + 64'(i));
    end
    step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    // Backpressure for 4 cycles mid-stream
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'h20 + 32'(i), 3'b011, 1'b0, !(i >= 3 && i < 7));
      if (i >= 4 && i < 7) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_data_held", 64'(out_data), 64'h22);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    // Flush in TWO with a beat offered
    step(1'b1, 1'b1, 32'h0000_00A1, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_00B2, 3'd2, 1'b0, 1'b0);
    chk("two_before_flush", 64'(in_ready), 64'd0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 3'd7, 1'b1, 1'b0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
    chk("flushed_beat_never_out", 64'(seen_dead), 64'd0);

    // Reset while in TWO
    step(1'b1, 1'b1, 32'h0000_0C01, 3'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0C02, 3'd5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0C03, 3'd6, 1'b0, 1'b0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
    chk("midrst_release_in_ready", 64'(in_ready), 64'd1);

    // Random handshakes with occasional flush
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    // Long stall: counter saturates
    step(1'b1, 1'b1, 32'h0000_0E01, 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    chk("long_stall_data", 64'(out_data), 64'h0E01);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_saturated", 64'(stall_cnt), 64'(SAT));
`endif
    step(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
